// File: rtl/riscv_pkg.sv
// Shared encodings for the multicycle controller: FSM states, supported opcodes and
// the ALU control field values driven towards the datapath.
package riscv_pkg;

    typedef enum logic [3:0] {
        StFetch    = 4'd0,
        StDecode   = 4'd1,
        StMemAddr  = 4'd2,
        StMemRead  = 4'd3,
        StMemWb    = 4'd4,
        StMemWrite = 4'd5,
        StExecute  = 4'd6,
        StRwb      = 4'd7,
        StBranch   = 4'd8
    } ctrl_state_e;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [1:0] ALU_OP_ADD   = 2'b00;
    localparam logic [1:0] ALU_OP_SUB   = 2'b01;
    localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

    localparam logic [1:0] ALU_B_RS2  = 2'b00;
    localparam logic [1:0] ALU_B_FOUR = 2'b01;
    localparam logic [1:0] ALU_B_IMM  = 2'b10;

    function automatic logic is_legal_opcode(input logic [6:0] op);
        return (op == OP_LOAD) || (op == OP_STORE) || (op == OP_RTYPE) || (op == OP_BRANCH);
    endfunction

endpackage

// File: rtl/multicycle_controller.sv
// Moore control FSM for a multicycle RISC-V datapath (LD, SD, R-format, BEQ) with
// memory wait states stretched by memReady.
module multicycle_controller
    import riscv_pkg::*;
#(
    parameter int unsigned OPCODE_WIDTH = 7,
    parameter int unsigned STATE_WIDTH  = 4
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [OPCODE_WIDTH-1:0] opcode,
    input  logic                    memReady,
    output logic                    pcWrite,
    output logic                    pcWriteCond,
    output logic                    pcSource,
    output logic                    iorD,
    output logic                    irWrite,
    output logic                    memoryRead,
    output logic                    memoryWrite,
    output logic                    memoryToRegister,
    output logic                    regWrite,
    output logic                    ALUSrcA,
    output logic [1:0]              ALUSrcB,
    output logic [1:0]              ALUOp,
    output logic                    illegalOpcode,
    output logic                    retired,
    output logic [STATE_WIDTH-1:0]  state
);

    ctrl_state_e state_q, state_d;
    logic [6:0]  op;

    assign op = opcode[6:0];

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= StFetch;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StFetch:    if (memReady) state_d = StDecode;
            StDecode: begin
                if (op == OP_LOAD || op == OP_STORE) begin
                    state_d = StMemAddr;
                end else if (op == OP_RTYPE) begin
                    state_d = StExecute;
                end else if (op == OP_BRANCH) begin
                    state_d = StBranch;
                end else begin
                    state_d = StFetch;
                end
            end
            StMemAddr:  state_d = (op == OP_LOAD) ? StMemRead : StMemWrite;
            StMemRead:  if (memReady) state_d = StMemWb;
            StMemWb:    state_d = StFetch;
            StMemWrite: if (memReady) state_d = StFetch;
            StExecute:  state_d = StRwb;
            StRwb:      state_d = StFetch;
            StBranch:   state_d = StFetch;
            default:    state_d = StFetch;
        endcase
    end

    // Outputs are forced low while reset is high so an abandoned access is dropped at once.
    always_comb begin
        pcWrite          = 1'b0;
        pcWriteCond      = 1'b0;
        pcSource         = 1'b0;
        iorD             = 1'b0;
        irWrite          = 1'b0;
        memoryRead       = 1'b0;
        memoryWrite      = 1'b0;
        memoryToRegister = 1'b0;
        regWrite         = 1'b0;
        ALUSrcA          = 1'b0;
        ALUSrcB          = ALU_B_RS2;
        ALUOp            = ALU_OP_ADD;
        illegalOpcode    = 1'b0;
        retired          = 1'b0;
        state            = '0;
        if (!reset) begin
            state = STATE_WIDTH'(state_q);
            case (state_q)
                StFetch: begin
                    memoryRead = 1'b1;
                    ALUSrcB    = ALU_B_FOUR;
                    irWrite    = memReady;
                    pcWrite    = memReady;
                end
                StDecode: begin
                    ALUSrcB       = ALU_B_IMM;
                    illegalOpcode = !is_legal_opcode(op);
                end
                StMemAddr: begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = ALU_B_IMM;
                end
                StMemRead: begin
                    memoryRead = 1'b1;
                    iorD       = 1'b1;
                end
                StMemWb: begin
                    regWrite         = 1'b1;
                    memoryToRegister = 1'b1;
                    retired          = 1'b1;
                end
                StMemWrite: begin
                    memoryWrite = 1'b1;
                    iorD        = 1'b1;
                    retired     = memReady;
                end
                StExecute: begin
                    ALUSrcA = 1'b1;
                    ALUOp   = ALU_OP_FUNCT;
                end
                StRwb: begin
                    regWrite = 1'b1;
                    retired  = 1'b1;
                end
                StBranch: begin
                    ALUSrcA     = 1'b1;
                    ALUOp       = ALU_OP_SUB;
                    pcWriteCond = 1'b1;
                    pcSource    = 1'b1;
                    retired     = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: directed scenarios plus randomized
// instruction streams with random wait states, checked cycle by cycle.
module tb_multicycle_controller;
    import riscv_pkg::*;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [6:0] opcode = '0;
    logic       memReady = 1'b0;
    logic       pcWrite, pcWriteCond, pcSource, iorD, irWrite, memoryRead, memoryWrite;
    logic       memoryToRegister, regWrite, ALUSrcA, illegalOpcode, retired;
    logic [1:0] ALUSrcB, ALUOp;
    logic [3:0] state;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       pc_source;
        logic       ior_d;
        logic       ir_write;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic       illegal;
        logic       retired;
    } ctl_t;

    ctl_t got_outs;
    assign got_outs = {pcWrite, pcWriteCond, pcSource, iorD, irWrite, memoryRead, memoryWrite,
                       memoryToRegister, regWrite, ALUSrcA, ALUSrcB, ALUOp, illegalOpcode,
                       retired};

    multicycle_controller #(
        .OPCODE_WIDTH(7),
        .STATE_WIDTH (4)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .opcode          (opcode),
        .memReady        (memReady),
        .pcWrite         (pcWrite),
        .pcWriteCond     (pcWriteCond),
        .pcSource        (pcSource),
        .iorD            (iorD),
        .irWrite         (irWrite),
        .memoryRead      (memoryRead),
        .memoryWrite     (memoryWrite),
        .memoryToRegister(memoryToRegister),
        .regWrite        (regWrite),
        .ALUSrcA         (ALUSrcA),
        .ALUSrcB         (ALUSrcB),
        .ALUOp           (ALUOp),
        .illegalOpcode   (illegalOpcode),
        .retired         (retired),
        .state           (state)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;
    int cyc_cnt, ret_cnt, ret_at;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Control word each step of an instruction must present.
    function automatic ctl_t expect_out(input string step, input logic mr, input logic ill);
        ctl_t e = '0;
        case (step)
            "FETCH": begin
                e.mem_read = 1'b1; e.alu_src_b = 2'b01; e.ir_write = mr; e.pc_write = mr;
            end
            "DECODE":   begin e.alu_src_b = 2'b10; e.illegal = ill; end
            "MEMADDR":  begin e.alu_src_a = 1'b1; e.alu_src_b = 2'b10; end
            "MEMREAD":  begin e.mem_read = 1'b1; e.ior_d = 1'b1; end
            "MEMWB":    begin e.reg_write = 1'b1; e.mem_to_reg = 1'b1; e.retired = 1'b1; end
            "MEMWRITE": begin e.mem_write = 1'b1; e.ior_d = 1'b1; e.retired = mr; end
            "EXECUTE":  begin e.alu_src_a = 1'b1; e.alu_op = 2'b10; end
            "RWB":      begin e.reg_write = 1'b1; e.retired = 1'b1; end
            "BRANCH": begin
                e.alu_src_a = 1'b1; e.alu_op = 2'b01; e.pc_write_cond = 1'b1;
                e.pc_source = 1'b1; e.retired = 1'b1;
            end
            default: ;
        endcase
        return e;
    endfunction

    task automatic step_cycle(input string step, input ctrl_state_e st, input logic [6:0] op,
                              input logic mr, input logic ill);
        @(negedge clock);
        reset    = 1'b0;
        opcode   = op;
        memReady = mr;
        #1;
        cyc_cnt++;
        if (retired === 1'b1) begin
            ret_cnt++;
            ret_at = cyc_cnt;
        end
        check_eq({step, " outs"}, 32'(got_outs), 32'(expect_out(step, mr, ill)));
        check_eq({step, " state"}, 32'(state), 32'(st));
    endtask

    task automatic reset_cycle(input logic mr);
        @(negedge clock);
        reset    = 1'b1;
        memReady = mr;
        opcode   = 7'($urandom);
        #1;
        check_eq("reset outs", 32'(got_outs), 32'd0);
        check_eq("reset state", 32'(state), 32'd0);
    endtask

    function automatic logic legal(input logic [6:0] op);
        return op == 7'b0000011 || op == 7'b0100011 || op == 7'b0110011 || op == 7'b1100011;
    endfunction

    // fw: memReady=0 cycles in FETCH; mw: in MEMREAD/MEMWRITE; abort_after>=0 resets
    // after that many mem wait cycles.
    task automatic run_instr(input logic [6:0] op, input int fw, input int mw,
                             input int abort_after);
        int base;
        int waits;
        cyc_cnt = 0;
        ret_cnt = 0;
        ret_at  = 0;
        waits   = fw;
        for (int i = 0; i < fw; i++) step_cycle("FETCH", StFetch, 7'($urandom), 1'b0, 1'b0);
        step_cycle("FETCH", StFetch, 7'($urandom), 1'b1, 1'b0);
        step_cycle("DECODE", StDecode, op, 1'($urandom), !legal(op));
        if (op == 7'b0000011 || op == 7'b0100011) begin
            step_cycle("MEMADDR", StMemAddr, op, 1'($urandom), 1'b0);
            for (int i = 0; i < mw; i++) begin
                if (i == abort_after) begin
                    reset_cycle(1'b0);
                    check_eq("abort no retire", 32'(ret_cnt), 32'd0);
                    return;
                end
                if (op == 7'b0000011) step_cycle("MEMREAD", StMemRead, op, 1'b0, 1'b0);
                else                  step_cycle("MEMWRITE", StMemWrite, op, 1'b0, 1'b0);
            end
            waits += mw;
            if (op == 7'b0000011) begin
                step_cycle("MEMREAD", StMemRead, op, 1'b1, 1'b0);
                step_cycle("MEMWB", StMemWb, op, 1'($urandom), 1'b0);
                base = 5;
            end else begin
                step_cycle("MEMWRITE", StMemWrite, op, 1'b1, 1'b0);
                base = 4;
            end
        end else if (op == 7'b0110011) begin
            step_cycle("EXECUTE", StExecute, op, 1'($urandom), 1'b0);
            step_cycle("RWB", StRwb, op, 1'($urandom), 1'b0);
            base = 4;
        end else if (op == 7'b1100011) begin
            step_cycle("BRANCH", StBranch, op, 1'($urandom), 1'b0);
            base = 3;
        end else begin
            base = 0;
        end
        if (base != 0) begin
            check_eq("retire count", 32'(ret_cnt), 32'd1);
            check_eq("latency", 32'(ret_at), 32'(base + waits));
        end else begin
            check_eq("illegal no retire", 32'(ret_cnt), 32'd0);
        end
    endtask

    initial begin
        logic [6:0] ops [4];
        logic [6:0] op;
        ops[0] = 7'b0000011;
        ops[1] = 7'b0100011;
        ops[2] = 7'b0110011;
        ops[3] = 7'b1100011;

        reset_cycle(1'b1);
        reset_cycle(1'b0);
        // Directed: R-format, LD with two MEMREAD waits, BEQ, illegal, then follow-up.
        run_instr(7'b0110011, 0, 0, -1);
        run_instr(7'b0000011, 0, 2, -1);
        check_eq("ld 2-wait latency", 32'(ret_at), 32'd7);
        run_instr(7'b1100011, 0, 0, -1);
        run_instr(7'b1111111, 0, 0, -1);
        run_instr(7'b0100011, 1, 0, -1);
        // Reset while a store is waiting, and while a load is waiting.
        run_instr(7'b0100011, 0, 3, 2);
        run_instr(7'b0000011, 0, 3, 1);
        run_instr(7'b0110011, 0, 0, -1);

        for (int n = 0; n < 200; n++) begin
            if ($urandom_range(0, 4) == 0) op = 7'($urandom);
            else                           op = ops[$urandom_range(0, 3)];
            if ($urandom_range(0, 9) == 0) begin
                reset_cycle(1'($urandom));
                run_instr(op, $urandom_range(0, 3), $urandom_range(1, 4), 0);
            end else begin
                run_instr(op, $urandom_range(0, 3), $urandom_range(0, 4), -1);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/multicycle_controller.md
MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 Parameter OPCODE_WIDTH, default 7, width of the opcode input.
REQ-002 Parameter STATE_WIDTH, default 4, width of the state output.
REQ-003 clock  input  1  single clock; all state changes occur on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset, sampled on the rising edge of clock.
REQ-005 opcode  input  7  instruction[6:0] from the instruction register; valid from DECODE onward.
REQ-006 memReady  input  1  memory access completes in the current cycle.
REQ-007 pcWrite  output  1  unconditional PC load.
REQ-008 pcWriteCond  output  1  PC load qualified by ALU zero in the datapath.
REQ-009 pcSource  output  1  PC mux select: 0 = ALU result, 1 = ALUOut register.
REQ-010 iorD  output  1  memory address select: 0 = PC, 1 = ALUOut.
REQ-011 irWrite  output  1  instruction register load.
REQ-012 memoryRead  output  1  memory read request.
REQ-013 memoryWrite  output  1  memory write request.
REQ-014 memoryToRegister  output  1  write-back mux select: 1 = memory data, 0 = ALUOut.
REQ-015 regWrite  output  1  register file write enable.
REQ-016 ALUSrcA  output  1  ALU operand A select: 0 = PC, 1 = rs1.
REQ-017 ALUSrcB  output  2  ALU operand B select: 00 = rs2, 01 = constant 4, 10 = immediate.
REQ-018 ALUOp  output  2  to the ALU controller: 00 = add, 01 = subtract/compare, 10 = funct-decoded.
REQ-019 illegalOpcode  output  1  one-cycle pulse when DECODE sees an unsupported opcode.
REQ-020 retired  output  1  one-cycle pulse in the final cycle of each completed instruction.
REQ-021 state  output  STATE_WIDTH  current state, for debug.

Function
REQ-022 The controller SHALL be a Moore FSM with states FETCH, DECODE, MEMADDR, MEMREAD, MEMWB, MEMWRITE, EXECUTE, RWB and BRANCH; outputs depend only on state and memReady.
REQ-023 Any output not listed for a state SHALL be 0.
REQ-024 FETCH: memoryRead=1, iorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, pcSource=0; irWrite and pcWrite equal memReady.
  - Transition: go to DECODE when memReady=1, otherwise stay in FETCH.
REQ-025 DECODE: ALUSrcA=0, ALUSrcB=10, ALUOp=00 (branch target into ALUOut).
  - Next state by opcode: 0000011 or 0100011 -> MEMADDR; 0110011 -> EXECUTE; 1100011 -> BRANCH; any other -> FETCH with illegalOpcode=1.
REQ-026 MEMADDR: ALUSrcA=1, ALUSrcB=10, ALUOp=00.
  - Next state: MEMREAD if opcode=0000011, else MEMWRITE.
REQ-027 MEMREAD: memoryRead=1, iorD=1; go to MEMWB on memReady, else stay.
REQ-028 MEMWB: regWrite=1, memoryToRegister=1, retired=1; go to FETCH.
REQ-029 MEMWRITE: memoryWrite=1, iorD=1; retired equals memReady; go to FETCH on memReady, else stay.
REQ-030 EXECUTE: ALUSrcA=1, ALUSrcB=00, ALUOp=10; go to RWB.
REQ-031 RWB: regWrite=1, memoryToRegister=0, retired=1; go to FETCH.
REQ-032 BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, pcWriteCond=1, pcSource=1, retired=1; go to FETCH.
REQ-033 With zero wait states, latency SHALL be BEQ 3 cycles, R-format 4, SD 4, LD 5; each memReady=0 cycle in a wait state adds exactly one cycle.
REQ-034 While waiting, memoryRead/memoryWrite SHALL be held steady and no register, PC or IR write SHALL occur.
REQ-035 An illegal opcode SHALL produce no regWrite, memoryWrite, pcWrite or retired.
REQ-036 memReady SHALL be ignored in every state other than FETCH, MEMREAD and MEMWRITE.

Reset
REQ-037 When reset=1 at a clock edge, the FSM SHALL enter FETCH from any state, including mid-wait, abandoning the instruction in flight.
REQ-038 In the reset cycle all outputs SHALL be 0 and state SHALL equal the FETCH encoding (0).
REQ-039 In the first cycle after reset deasserts, FETCH outputs SHALL apply.

Structure
REQ-040 The state encodings, the four opcode constants and the ALUOp/ALUSrcB encodings SHALL live in a shared package, riscv_pkg.
REQ-041 The block SHALL have no sub-module: one state register plus combinational next-state and output logic.

Verification
REQ-042 Reset, then opcode=0110011 with memReady=1: sequence FETCH, DECODE, EXECUTE, RWB; regWrite=1 only in cycle 4; retired pulses once.
REQ-043 opcode=0000011 with memReady=0 for 2 cycles in MEMREAD: 7 cycles total; memoryRead held high through the wait; regWrite and memoryToRegister high in the MEMWB cycle.
REQ-044 opcode=1100011: 3 cycles; pcWriteCond=1, ALUOp=01 and pcSource=1 in cycle 3.
REQ-045 opcode=1111111: illegalOpcode pulses in DECODE, next state is FETCH, and regWrite, memoryWrite, pcWrite and retired all stay 0.
REQ-046 Assert reset while in MEMWRITE with memReady=0: next state is FETCH, memoryWrite=0 in the reset cycle, and no retired pulse.
